target_read_responder: RTL and testbench
========================================

// Module: target_read_responder
// PURPOSE
//  Target-side FSM ("C") behind the two-requester shared-access arbiter.
//  Accepts a one-cycle start plus an argument word, performs one byte read over an
//  Avalon-style word memory port, returns the byte and pulses finished.
//  A cycle timeout guarantees that finished always comes, so the arbiter cannot hang.
// PARAMETERS
//  ARG_W        32   width of arguments (byte address in low bits)
//  DATA_W       8    width of received_data; fixed at 8 (one byte lane of 32-bit word)
//  ADDR_W       23   width of mem_address (word address)
//  TIMEOUT_CYC  256  max cycles from start accept to read data before error finish (>=4)
// PORTS
//  clk                  in   1       system clock, all logic on posedge
//  reset                in   1       synchronous, active-high
//  start                in   1       from arbiter start_target_state_machine; 1-cycle pulse
//  arguments            in   ARG_W   from arbiter output_arguments; sampled only when start=1
//  finished             out  1       to arbiter target_state_machine_finished; 1-cycle pulse
//  received_data        out  DATA_W  to arbiter received_data; held until next accepted start
//  error                out  1       1 = last transaction timed out; held like received_data
//  busy                 out  1       1 in any state other than IDLE
//  mem_address          out  ADDR_W  word address = arguments[ADDR_W+1:2] latched at start
//  mem_read             out  1       read strobe, held while mem_waitrequest=1
//  mem_waitrequest      in   1       1 = memory has not accepted the read
//  mem_readdata         in   32      read word; valid only with mem_readdatavalid
//  mem_readdatavalid    in   1       read data strobe
// BEHAVIOUR
//  Reset (sync): state=IDLE; finished, error, busy, mem_read = 0; received_data = 0;
//   mem_address = 0; lane = 0; timeout count = 0. Reset mid-transaction drops mem_read on
//   the next edge. No finish is sent for the aborted read.
//  States: IDLE, ISSUE, WAIT_DATA, DONE.
//  IDLE: start=1 -> latch word addr and lane=arguments[1:0], clear count, go ISSUE.
//   mem_readdatavalid in IDLE (stale data) is ignored.
//  ISSUE: mem_read=1. When mem_waitrequest=0, the read is accepted and the next state is
//   WAIT_DATA. If mem_readdatavalid=1 in that same cycle, capture the data and go DONE.
//  WAIT_DATA: mem_read=0. When mem_readdatavalid=1: received_data <= mem_readdata[8*lane+:8],
//   error <= 0, go DONE.
//  Timeout: count increments on every cycle in ISSUE or WAIT_DATA. When count==TIMEOUT_CYC-1
//   and no data is captured in that cycle: received_data <= 8'hFF, error <= 1, go DONE.
//   If data is captured in the same cycle, the data wins.
//  DONE: finished=1 for exactly this cycle, then IDLE. received_data and error are already
//   stable in DONE and hold through the arbiter register_data cycle.
//  start while busy=1: ignored. A read is never queued or restarted.
//  Lane select: lane 0 = bits[7:0], lane 3 = bits[31:24]. Arguments above bit ADDR_W+1 are ignored.
//  Latency: start in cycle 0; mem_read in cycle 1; waitrequest=0 in cycle 1 and
//   readdatavalid in cycle 3 give finished in cycle 4. Minimum is finished in cycle 2
//   (accept and data both in cycle 1).
//  The first finished can never occur earlier than 2 cycles after start. The arbiter is
//   therefore already in its wait state.
//  Outputs finished, busy and mem_read are decoded from state. No combinational path
//   exists from start to any output.
// TESTING
//  T1 start, arguments=32'h0000_0106; waitreq=0; rdv in cycle 3 with data 32'hA1B2C3D4
//   -> mem_address=23'h41, lane 2, received_data=8'hB2, finished pulses only in cycle 4, error=0.
//  T2 waitrequest held 1 for 5 cycles -> mem_read high for 6 cycles, address stable;
//   finished 1 cycle after rdv.
//  T3 TIMEOUT_CYC=8, no rdv -> finished in cycle 9 with received_data=8'hFF, error=1;
//   a following good read clears error.
//  T4 start pulses during WAIT_DATA and DONE -> exactly one finished; no second mem_read;
//   captured byte is from the first arguments.
//  T5 reset asserted in WAIT_DATA, rdv arrives 1 cycle after reset -> state IDLE;
//   no finished; received_data=0.
//  T6 back-to-back via the arbiter with A and B (addresses 0x3, 0x100) -> A gets lane-3
//   byte and B gets lane-0 byte of their respective words.

Source files
------------

// File: rtl/target_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : target_read_responder
// Purpose  : Target-side responder behind the two-requester shared-access
//            arbiter. Accepts a one-cycle start with an argument word,
//            performs a single byte read over an Avalon-style word memory
//            port and returns the selected byte with a one-cycle finished
//            pulse. A cycle timeout guarantees that finished always arrives.
// Ports    : clk                  - system clock, rising edge
//            reset                - synchronous, active-high
//            i_start              - 1-cycle start pulse from the arbiter
//            i_arguments          - byte address in the low bits, sampled on start
//            o_finished           - 1-cycle completion pulse (DONE state)
//            o_received_data      - returned byte, held until the next accepted start
//            o_error              - last transaction timed out, held like the data
//            o_busy               - any state other than IDLE
//            o_mem_address        - word address latched on start
//            o_mem_read           - read strobe, held while waitrequest is high
//            i_mem_waitrequest    - memory has not yet accepted the read
//            i_mem_readdata       - 32-bit read word
//            i_mem_readdatavalid  - read data strobe
// Revision : 1.0 - initial release
// ============================================================================
module target_read_responder #(
  parameter int ARG_W       = 32,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 23,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ARG_W-1:0]  i_arguments,
  output logic              o_finished,
  output logic [DATA_W-1:0] o_received_data,
  output logic              o_error,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_read,
  input  logic              i_mem_waitrequest,
  input  logic [31:0]       i_mem_readdata,
  input  logic              i_mem_readdatavalid
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_count;
  logic [1:0]          r_lane;
  logic [DATA_W-1:0]   r_received_data;
  logic                r_error;
  logic [ADDR_W-1:0]   r_mem_address;

  logic                w_in_xfer;
  logic                w_accept;
  logic                w_capture;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_lane_byte;

  // Only bits [ADDR_W+1:0] of the argument carry meaning; the rest are
  // deliberately dropped.
  generate
    if (ARG_W > ADDR_W + 2) begin : g_unused_args
      logic w_unused_args;
      assign w_unused_args = ^i_arguments[ARG_W-1:ADDR_W+2];
    end else begin : g_no_unused_args
    end
  endgenerate

  assign w_in_xfer = (r_state == S_ISSUE) || (r_state == S_WAIT_DATA);
  assign w_accept  = (r_state == S_ISSUE) && !i_mem_waitrequest;

  // Data is only meaningful once the read has been accepted: either in the
  // accepting cycle itself or while waiting for it. Valid strobes seen in
  // IDLE/DONE or before acceptance are stale and ignored.
  assign w_capture = i_mem_readdatavalid && (w_accept || (r_state == S_WAIT_DATA));

  // Captured data in the last allowed cycle beats the timeout.
  assign w_timeout = w_in_xfer && (r_count == C_CNT_LAST) && !w_capture;

  assign w_lane_byte = i_mem_readdata[{r_lane, 3'b000} +: DATA_W];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    o_finished   = 1'b0;
    o_busy       = 1'b1;
    o_mem_read   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_mem_read = 1'b1;
        if (w_capture || w_timeout) begin
          w_next_state = S_DONE;
        end else if (w_accept) begin
          w_next_state = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (w_capture || w_timeout) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        o_finished   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count         <= '0;
      r_lane          <= 2'd0;
      r_mem_address   <= '0;
      r_received_data <= '0;
      r_error         <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_mem_address <= i_arguments[ADDR_W+1:2];
        r_lane        <= i_arguments[1:0];
        r_count       <= '0;
      end else if (w_in_xfer) begin
        // Never wraps: the transfer leaves ISSUE/WAIT_DATA at C_CNT_LAST.
        r_count <= r_count + CNT_W'(1);
      end

      if (w_capture) begin
        r_received_data <= w_lane_byte;
        r_error         <= 1'b0;
      end else if (w_timeout) begin
        r_received_data <= {DATA_W{1'b1}};
        r_error         <= 1'b1;
      end
    end
  end

  assign o_received_data = r_received_data;
  assign o_error         = r_error;
  assign o_mem_address   = r_mem_address;

endmodule
`default_nettype wire

// File: tb/tb_target_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_target_read_responder
// Purpose  : Directed self-checking bench for target_read_responder, built
//            with an 8-cycle timeout so timeout boundaries are reachable.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_target_read_responder;

  localparam int C_TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [31:0] i_arguments;
  logic        o_finished;
  logic [7:0]  o_received_data;
  logic        o_error;
  logic        o_busy;
  logic [22:0] o_mem_address;
  logic        o_mem_read;
  logic        i_mem_waitrequest;
  logic [31:0] i_mem_readdata;
  logic        i_mem_readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  target_read_responder #(
    .ARG_W       (32),
    .DATA_W      (8),
    .ADDR_W      (23),
    .TIMEOUT_CYC (C_TIMEOUT)
  ) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .i_start             (i_start),
    .i_arguments         (i_arguments),
    .o_finished          (o_finished),
    .o_received_data     (o_received_data),
    .o_error             (o_error),
    .o_busy              (o_busy),
    .o_mem_address       (o_mem_address),
    .o_mem_read          (o_mem_read),
    .i_mem_waitrequest   (i_mem_waitrequest),
    .i_mem_readdata      (i_mem_readdata),
    .i_mem_readdatavalid (i_mem_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_start             = 1'b0;
    i_arguments         = 32'h0;
    i_mem_waitrequest   = 1'b0;
    i_mem_readdata      = 32'h0;
    i_mem_readdatavalid = 1'b0;
  endtask

  // One transaction. Cycle 0 carries the start; waitrequest is high in cycles
  // 1..n_wait; readdatavalid is pulsed in cycle rdv_cyc (-1 = never). Extra
  // start pulses with a different argument may be issued in cycles xa/xb.
  // After the expected finish, junk valid data is offered to prove it is
  // ignored in IDLE and the result is held.
  task automatic run_txn(input string tag, input logic [31:0] args,
                         input int n_wait, input int rdv_cyc, input logic [31:0] rdata,
                         input int xa, input int xb, input int exp_fin,
                         input logic [7:0] exp_data, input logic exp_err,
                         input logic [22:0] exp_addr, input int exp_reads);
    int   fin_cnt  = 0;
    int   fin_cyc  = -1;
    int   reads    = 0;
    int   busy_cnt = 0;
    logic addr_ok  = 1'b1;
    logic [7:0] fin_data = 8'h0;
    logic       fin_err  = 1'b0;
    for (int c = 0; c < exp_fin + 4; c++) begin
      i_start           = (c == 0) || (c == xa) || (c == xb);
      i_arguments       = (c == 0) ? args : 32'hFFFF_FFFF;
      i_mem_waitrequest = (c >= 1) && (c <= n_wait);
      if (c == rdv_cyc) begin
        i_mem_readdatavalid = 1'b1;
        i_mem_readdata      = rdata;
      end else if (c > exp_fin) begin
        i_mem_readdatavalid = 1'b1;
        i_mem_readdata      = 32'hDEAD_BEEF;
      end else begin
        i_mem_readdatavalid = 1'b0;
        i_mem_readdata      = 32'h5A5A_5A5A;
      end
      @(negedge clk);
      if (o_finished) begin
        fin_cnt++;
        if (fin_cyc < 0) begin
          fin_cyc  = c;
          fin_data = o_received_data;
          fin_err  = o_error;
        end
      end
      if (o_mem_read) begin
        reads++;
        if (o_mem_address !== exp_addr) addr_ok = 1'b0;
      end
      if (o_busy) busy_cnt++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    chk({tag, ".fin_count"}, fin_cnt, 1);
    chk({tag, ".fin_cycle"}, fin_cyc, exp_fin);
    chk({tag, ".reads"},     reads, exp_reads);
    chk({tag, ".busy_cyc"},  busy_cnt, exp_fin);
    chk({tag, ".addr_ok"},   {31'd0, addr_ok}, 32'd1);
    chk({tag, ".fin_data"},  {24'd0, fin_data}, {24'd0, exp_data});
    chk({tag, ".fin_err"},   {31'd0, fin_err}, {31'd0, exp_err});
    chk({tag, ".hold_data"}, {24'd0, o_received_data}, {24'd0, exp_data});
    chk({tag, ".hold_err"},  {31'd0, o_error}, {31'd0, exp_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_fin;
    int bad_busy;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.finished", {31'd0, o_finished}, 32'd0);
    chk("rst.busy",     {31'd0, o_busy}, 32'd0);
    chk("rst.mem_read", {31'd0, o_mem_read}, 32'd0);
    chk("rst.data",     {24'd0, o_received_data}, 32'd0);
    chk("rst.error",    {31'd0, o_error}, 32'd0);
    chk("rst.addr",     {9'd0, o_mem_address}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // tag          args          nw  rdv data           xa  xb fin  byte   err addr      reads
    run_txn("t1",   32'h0000_0106, 0,  3, 32'hA1B2_C3D4, -1, -1, 4, 8'hB2, 0, 23'h41,   1);
    run_txn("t2",   32'h0000_0A0D, 5,  7, 32'h1122_3344, -1, -1, 8, 8'h33, 0, 23'h283,  6);
    run_txn("tmin", 32'h0000_0010, 0,  1, 32'hCAFE_BABE, -1, -1, 2, 8'hBE, 0, 23'h4,    1);
    run_txn("t3",   32'h0000_0020, 0, -1, 32'h0,         -1, -1, 9, 8'hFF, 1, 23'h8,    1);
    run_txn("t3ok", 32'h0000_0007, 2,  4, 32'h89AB_CDEF, -1, -1, 5, 8'h89, 0, 23'h1,    3);
    run_txn("tow",  32'hFE00_0004, 20,-1, 32'h0,         -1, -1, 9, 8'hFF, 1, 23'h1,    8);
    run_txn("tedg", 32'h0000_0002, 0,  8, 32'h0077_0000, -1, -1, 9, 8'h77, 0, 23'h0,    1);
    run_txn("t4",   32'h0000_0105, 0,  3, 32'hA1B2_C3D4,  2,  4, 4, 8'hC3, 0, 23'h41,   1);
    run_txn("t6a",  32'h0000_0003, 0,  2, 32'h1234_5678, -1, -1, 3, 8'h12, 0, 23'h0,    1);
    run_txn("t6b",  32'h0000_0100, 0,  2, 32'h9ABC_DEF0, -1, -1, 3, 8'hF0, 0, 23'h40,   1);

    // Reset while waiting for data; the late data must not produce a finish.
    i_start     = 1'b1;
    i_arguments = 32'h0000_0106;
    @(posedge clk); #1;
    idle_inputs();                       // cycle 1: ISSUE, accepted
    @(posedge clk); #1;
    reset = 1'b1;                        // cycle 2: WAIT_DATA
    @(posedge clk); #1;
    reset               = 1'b0;
    i_mem_readdatavalid = 1'b1;          // cycle 3: data after reset
    i_mem_readdata      = 32'hA1B2_C3D4;
    bad_fin  = 0;
    bad_busy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_finished) bad_fin++;
      if (o_busy || o_mem_read) bad_busy++;
      @(posedge clk); #1;
      idle_inputs();
    end
    chk("t5.no_finish", bad_fin, 0);
    chk("t5.idle",      bad_busy, 0);
    chk("t5.data",      {24'd0, o_received_data}, 32'd0);
    chk("t5.error",     {31'd0, o_error}, 32'd0);
    chk("t5.addr",      {9'd0, o_mem_address}, 32'd0);

    run_txn("t5rec", 32'h0000_0106, 0,  3, 32'hA1B2_C3D4, -1, -1, 4, 8'hB2, 0, 23'h41,   1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
